exe_mdu: RTL and testbench

EXE_MDU -- requirements
Module: exe_mdu

---
 rtl/exe_mdu.sv | 149 ++++++++++++++
 tb/tb_exe_mdu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/exe_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : exe_mdu
//  Purpose  : Multi-cycle multiply/divide unit for the E stage. Owns the HI/LO
//             register pair. MULT/MULTU/DIV/DIVU latch their operands and count
//             down a fixed busy period. The result is written to HI/LO on the
//             edge where the count reaches zero. MTHI/MTLO write HI/LO
//             directly when the unit is idle. MFHI/MFLO read HI/LO
//             combinationally.
//  Ports    : clk, reset    - clock, synchronous active-high reset
//             ir_e          - E-stage instruction word
//             rs_e, rt_e    - forwarded E-stage operands
//             d_is_md       - D-stage instruction touches HI/LO or the MDU
//             md_out        - HI/LO read data for MFHI/MFLO, else 0
//             hi, lo        - architectural HI/LO registers
//             busy          - operation in progress
//             xstall        - stall request for the D-to-E register
//  Revision : 1.0 - initial release
// ============================================================================
module exe_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir_e,
   input  logic [31:0] rs_e,
   input  logic [31:0] rt_e,
   input  logic        d_is_md,
   output logic [31:0] md_out,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        xstall
);

   localparam logic [5:0] c_F_MFHI  = 6'h10;
   localparam logic [5:0] c_F_MTHI  = 6'h11;
   localparam logic [5:0] c_F_MFLO  = 6'h12;
   localparam logic [5:0] c_F_MTLO  = 6'h13;
   localparam logic [5:0] c_F_MULT  = 6'h18;
   localparam logic [5:0] c_F_DIVU  = 6'h1B;

   localparam logic [3:0] c_MULT_CNT = MULT_CYCLES[3:0];
   localparam logic [3:0] c_DIV_CNT  = DIV_CYCLES[3:0];

   // Latched operation: bit 1 = divide, bit 0 = unsigned
   logic [31:0] r_rs;
   logic [31:0] r_rt;
   logic [1:0]  r_op;
   logic [3:0]  r_cnt;

   // ---------------------------------------------------------------- decode
   logic        w_rtype;
   logic [5:0]  w_funct;
   logic        w_is_muldiv;
   logic        w_is_mfhi;
   logic        w_is_mflo;
   logic        w_is_mthi;
   logic        w_is_mtlo;
   logic        w_start;
   logic        w_unused_bits;

   assign w_rtype       = (ir_e[31:26] == 6'd0);
   assign w_funct       = ir_e[5:0];
   assign w_is_muldiv   = w_rtype && (w_funct >= c_F_MULT) && (w_funct <= c_F_DIVU);
   assign w_is_mfhi     = w_rtype && (w_funct == c_F_MFHI);
   assign w_is_mflo     = w_rtype && (w_funct == c_F_MFLO);
   assign w_is_mthi     = w_rtype && (w_funct == c_F_MTHI);
   assign w_is_mtlo     = w_rtype && (w_funct == c_F_MTLO);
   assign w_unused_bits = ^ir_e[25:6];

   assign busy    = (r_cnt != 4'd0);
   assign w_start = w_is_muldiv && !busy;
   assign xstall  = d_is_md && (w_start || busy);

   // No bypass of a pending result: reads always see the current registers.
   assign md_out = w_is_mfhi ? hi :
                   w_is_mflo ? lo : 32'd0;

   // -------------------------------------------------------------- multiply
   // Sign- or zero-extending to 64 bits lets one 64x64 multiply (low half kept)
   // serve both signed and unsigned forms.
   logic [63:0] w_a64;
   logic [63:0] w_b64;
   logic [63:0] w_prod;

   assign w_a64  = r_op[0] ? {32'd0, r_rs} : {{32{r_rs[31]}}, r_rs};
   assign w_b64  = r_op[0] ? {32'd0, r_rt} : {{32{r_rt[31]}}, r_rt};
   assign w_prod = w_a64 * w_b64;

   // ---------------------------------------------------------------- divide
   // Signed divide is done on magnitudes, with the signs fixed up afterwards.
   // 0x80000000 / -1 then yields quotient 0x80000000, remainder 0 with no
   // special case.
   logic        w_neg_a;
   logic        w_neg_b;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic        w_div0;
   logic [31:0] w_quo_u;
   logic [31:0] w_rem_u;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   assign w_neg_a = !r_op[0] && r_rs[31];
   assign w_neg_b = !r_op[0] && r_rt[31];
   assign w_abs_a = w_neg_a ? (32'd0 - r_rs) : r_rs;
   assign w_abs_b = w_neg_b ? (32'd0 - r_rt) : r_rt;
   assign w_div0  = (r_rt == 32'd0);
   assign w_quo_u = w_div0 ? 32'd0 : (w_abs_a / w_abs_b);
   assign w_rem_u = w_div0 ? 32'd0 : (w_abs_a % w_abs_b);
   assign w_quo   = (w_neg_a ^ w_neg_b) ? (32'd0 - w_quo_u) : w_quo_u;
   assign w_rem   = w_neg_a ? (32'd0 - w_rem_u) : w_rem_u;

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rs  <= 32'd0;
         r_rt  <= 32'd0;
         r_op  <= 2'd0;
         r_cnt <= 4'd0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else if (w_start) begin
         r_rs  <= rs_e;
         r_rt  <= rt_e;
         r_op  <= w_funct[1:0];
         r_cnt <= w_funct[1] ? c_DIV_CNT : c_MULT_CNT;
      end else if (busy) begin
         // While busy, MTHI/MTLO and new multiply/divide ops are ignored.
         r_cnt <= r_cnt - 4'd1;
         if (r_cnt == 4'd1) begin
            if (!r_op[1]) begin
               hi <= w_prod[63:32];
               lo <= w_prod[31:0];
            end else if (!w_div0) begin
               hi <= w_rem;
               lo <= w_quo;
            end
         end
      end else begin
         if (w_is_mthi) hi <= rs_e;
         if (w_is_mtlo) lo <= rs_e;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_exe_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exe_mdu
//  Purpose  : Directed, self-checking bench for exe_mdu with hand-computed
//             expected HI/LO values, busy/xstall timing and reset abort.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exe_mdu;

   localparam logic [31:0] c_MFHI  = 32'h0000_0010;
   localparam logic [31:0] c_MTHI  = 32'h0000_0011;
   localparam logic [31:0] c_MFLO  = 32'h0000_0012;
   localparam logic [31:0] c_MTLO  = 32'h0000_0013;
   localparam logic [31:0] c_MULT  = 32'h0000_0018;
   localparam logic [31:0] c_MULTU = 32'h0000_0019;
   localparam logic [31:0] c_DIV   = 32'h0000_001A;
   localparam logic [31:0] c_DIVU  = 32'h0000_001B;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ir_e;
   logic [31:0] rs_e;
   logic [31:0] rt_e;
   logic        d_is_md;
   logic [31:0] md_out;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        xstall;

   int n_vec = 0;
   int n_err = 0;

   exe_mdu #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .ir_e    (ir_e),
      .rs_e    (rs_e),
      .rt_e    (rt_e),
      .d_is_md (d_is_md),
      .md_out  (md_out),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .xstall  (xstall)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one multiply/divide, checks busy/xstall in every cycle, checks that
   // HI is still at its old value just before write-back, then checks HI/LO.
   // mid_ir is presented for one cycle during the busy period.
   task automatic run_op(input string tag, input logic [31:0] ir, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic md,
                         input logic [31:0] mid_ir, input logic [31:0] mid_rs,
                         input logic [31:0] old_hi,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      d_is_md = md;
      ir_e    = ir;
      rs_e    = a;
      rt_e    = b;
      #1;
      check_eq({tag, " xstall@start"}, {31'd0, xstall}, {31'd0, md});
      check_eq({tag, " busy@start"}, {31'd0, busy}, 32'd0);
      tick();
      for (int i = 0; i < n; i++) begin
         if (i == 1) begin
            ir_e = mid_ir;
            rs_e = mid_rs;
            rt_e = mid_rs;
         end else begin
            ir_e = 32'd0;
            rs_e = 32'd0;
            rt_e = 32'd0;
         end
         #1;
         check_eq({tag, " busy"}, {31'd0, busy}, 32'd1);
         check_eq({tag, " xstall@busy"}, {31'd0, xstall}, {31'd0, md});
         if (i == n - 1) check_eq({tag, " hi@last"}, hi, old_hi);
         tick();
      end
      ir_e = 32'd0;
      #1;
      check_eq({tag, " busy@end"}, {31'd0, busy}, 32'd0);
      check_eq({tag, " xstall@end"}, {31'd0, xstall}, 32'd0);
      check_eq({tag, " hi"}, hi, exp_hi);
      check_eq({tag, " lo"}, lo, exp_lo);
      d_is_md = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset   = 1'b1;
      ir_e    = 32'd0;
      rs_e    = 32'd0;
      rt_e    = 32'd0;
      d_is_md = 1'b0;
      tick();
      tick();
      check_eq("rst hi", hi, 32'd0);
      check_eq("rst lo", lo, 32'd0);
      check_eq("rst busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      tick();

      run_op("MULT -2*3",    c_MULT,  32'hFFFF_FFFE, 32'd3,         5,  1'b0, 32'd0, 32'd0,
             32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("MULTU max*max", c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  1'b0, 32'd0, 32'd0,
             32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("MULTU 2^16sq", c_MULTU, 32'h0001_0000, 32'h0001_0000, 5,  1'b1, 32'd0, 32'd0,
             32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000);
      run_op("DIV -7/2",     c_DIV,   32'hFFFF_FFF9, 32'd2,         10, 1'b1, 32'd0, 32'd0,
             32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      // Divide by zero leaves HI/LO alone; the MTLO issued while busy is ignored.
      run_op("DIVU 7/0",     c_DIVU,  32'd7,         32'd0,         10, 1'b0, c_MTLO, 32'hDEAD_BEEF,
             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("DIV min/-1",   c_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'd0, 32'd0,
             32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      // A MULT presented while busy must not restart or change the divide.
      run_op("DIV 7/-2",     c_DIV,   32'd7,         32'hFFFF_FFFE, 10, 1'b1, c_MULT, 32'd9,
             32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("DIVU 100/7",   c_DIVU,  32'd100,       32'd7,         10, 1'b0, 32'd0, 32'd0,
             32'h0000_0001, 32'h0000_0002, 32'h0000_000E);

      // MTHI / MTLO while idle, then read back through MFHI / MFLO
      ir_e = c_MTHI;
      rs_e = 32'h1234_5678;
      #1;
      check_eq("md_out non-MF", md_out, 32'd0);
      tick();
      check_eq("MTHI hi", hi, 32'h1234_5678);
      check_eq("MTHI lo kept", lo, 32'h0000_000E);
      ir_e = c_MFHI;
      #1;
      check_eq("MFHI md_out", md_out, 32'h1234_5678);
      ir_e = c_MTLO;
      rs_e = 32'h0BAD_F00D;
      tick();
      check_eq("MTLO lo", lo, 32'h0BAD_F00D);
      ir_e = c_MFLO;
      #1;
      check_eq("MFLO md_out", md_out, 32'h0BAD_F00D);

      // Reset three cycles into a MULT aborts it with no late write-back.
      ir_e = c_MULTU;
      rs_e = 32'd2;
      rt_e = 32'd3;
      tick();
      ir_e = c_MFHI;
      #1;
      check_eq("MFHI no bypass", md_out, 32'h1234_5678);
      tick();
      tick();
      reset   = 1'b1;
      ir_e    = c_MULT;
      d_is_md = 1'b1;
      tick();
      check_eq("abort busy", {31'd0, busy}, 32'd0);
      check_eq("abort hi", hi, 32'd0);
      check_eq("abort lo", lo, 32'd0);
      check_eq("xstall in reset", {31'd0, xstall}, 32'd1);
      reset   = 1'b0;
      ir_e    = 32'd0;
      d_is_md = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check_eq("no late hi", hi, 32'd0);
      check_eq("no late lo", lo, 32'd0);
      check_eq("no late busy", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
